// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer between the core load/store path (port 0) and the
// loader/debug port (port 1), with alignment/funct3 checking in front of datamemory.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_W-1:0]     rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_last;
    logic r_winner;
    logic r_we;
    logic r_bad;

    logic                  w_any_req;
    logic                  w_win_id;
    logic                  w_sel_we;
    logic [DM_ADDRESS-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [2:0]            w_sel_funct3;
    logic                  w_sel_bad;

    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        end else begin
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
        end
        misaligned = (f3 == 3'b010 && lsb != 2'b00) ||
                     ((f3 == 3'b001 || f3 == 3'b101) && lsb[0]);
        return illegal || misaligned;
    endfunction

    // On a tie the requester that did not win last time gets the grant.
    assign w_any_req    = req0 || req1;
    assign w_win_id     = (req0 && req1) ? ~r_last : req1;
    assign w_sel_we     = w_win_id ? we1      : we0;
    assign w_sel_addr   = w_win_id ? addr1    : addr0;
    assign w_sel_wdata  = w_win_id ? wdata1   : wdata0;
    assign w_sel_funct3 = w_win_id ? funct3_1 : funct3_0;
    assign w_sel_bad    = access_bad(w_sel_we, w_sel_funct3, w_sel_addr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = ISSUE;
            ISSUE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        case (r_state)
            ISSUE: begin
                MemRead  = !r_bad && !r_we;
                MemWrite = !r_bad && r_we;
            end
            RESP: begin
                ack0 = !r_winner;
                ack1 = r_winner;
                err0 = !r_winner && r_bad;
                err1 = r_winner && r_bad;
            end
            default: ;
        endcase
    end

    // Request fields are captured at grant, so requesters may change them once acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_winner <= 1'b0;
            r_we     <= 1'b0;
            r_bad    <= 1'b0;
            a        <= '0;
            wd       <= '0;
            Funct3   <= '0;
            rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_win_id;
                        r_we     <= w_sel_we;
                        r_bad    <= w_sel_bad;
                        a        <= w_sel_addr;
                        wd       <= w_sel_wdata;
                        Funct3   <= w_sel_funct3;
                    end
                end
                ISSUE: rdata <= (!r_bad && !r_we) ? rd : '0;
                RESP:  r_last <= r_winner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed datamemory model on the memory side.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [2:0]    funct3_0, funct3_1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic          MemRead, MemWrite;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [2:0]    Funct3;
    logic [DW-1:0] rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .funct3_0(funct3_0), .funct3_1(funct3_1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
        .rd(rd)
    );

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   ack_cyc[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc    = 0;
    int   ack_cnt = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   rd_cyc = -1;
    int   wr_cyc = -1;

    logic [7:0] mem     [0:511];
    logic [7:0] ref_mem [0:511];
    logic [AW-1:0] a1, a2, a3;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_bad(input logic we, input logic [AW-1:0] ad, input logic [2:0] f3);
        logic legal;
        logic aligned;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (f3[1:0])
            2'b01:   aligned = ~ad[0];
            2'b10:   aligned = (ad[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        return !(legal && aligned);
    endfunction

    // Datamemory model: combinational read, byte/half/word write on the clock edge.
    assign a1 = a + 9'd1;
    assign a2 = a + 9'd2;
    assign a3 = a + 9'd3;
    assign rd = extend(Funct3, mem[a], mem[a1], mem[a2], mem[a3]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemWrite) begin
            case (Funct3)
                3'b000: mem[a] <= wd[7:0];
                3'b001: begin mem[a] <= wd[7:0]; mem[a1] <= wd[15:8]; end
                3'b010: begin
                    mem[a]  <= wd[7:0];   mem[a1] <= wd[15:8];
                    mem[a2] <= wd[23:16]; mem[a3] <= wd[31:24];
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (MemRead) begin rd_cnt++; rd_cyc = cyc; end
        if (MemWrite) begin wr_cnt++; wr_cyc = cyc; end
        if (ack0 || ack1) begin
            check_val("ack_exclusive", 32'(ack0 && ack1), 32'd0);
            check_val("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("ack_id", 32'(ack1), 32'(e.id));
                check_val("ack_err", 32'(ack1 ? err1 : err0), 32'(e.err));
                check_val("ack_rdata", rdata, e.rdata);
            end
            $display("cycle %0d: ack%0d err=%0b rdata=0x%08h", cyc, ack1, ack1 ? err1 : err0, rdata);
            ack_cnt++;
            ack_cyc.push_back(cyc);
        end
    end

    task automatic push_exp(input logic id, input logic we, input logic [AW-1:0] ad,
                            input logic [31:0] wdv, input logic [2:0] f3);
        exp_t e;
        logic [AW-1:0] p1, p2, p3;
        p1 = ad + 9'd1; p2 = ad + 9'd2; p3 = ad + 9'd3;
        e.id    = id;
        e.err   = ref_bad(we, ad, f3);
        e.rdata = (e.err || we) ? 32'h0 : extend(f3, ref_mem[ad], ref_mem[p1], ref_mem[p2], ref_mem[p3]);
        if (!e.err && we) begin
            ref_mem[ad] = wdv[7:0];
            if (f3 != 3'b000) ref_mem[p1] = wdv[15:8];
            if (f3 == 3'b010) begin ref_mem[p2] = wdv[23:16]; ref_mem[p3] = wdv[31:24]; end
        end
        sb_q.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic r, input logic we, input logic [AW-1:0] ad,
                           input logic [31:0] wdv, input logic [2:0] f3);
        if (id) begin req1 = r; we1 = we; addr1 = ad; wdata1 = wdv; funct3_1 = f3; end
        else    begin req0 = r; we0 = we; addr0 = ad; wdata0 = wdv; funct3_0 = f3; end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("ack_count", ack_cnt, target);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic access(input logic id, input logic we, input logic [AW-1:0] ad,
                          input logic [31:0] wdv, input logic [2:0] f3);
        int base, start, rc, wc;
        logic good;
        @(negedge clk); #1;
        good = !ref_bad(we, ad, f3);
        push_exp(id, we, ad, wdv, f3);
        base = ack_cnt; start = cyc; rc = rd_cnt; wc = wr_cnt;
        set_req(id, 1'b1, we, ad, wdv, f3);
        wait_acks(base + 1, 20);
        set_req(id, 1'b0, 1'b0, '0, '0, 3'b000);
        if (ack_cyc.size() > base) check_val("ack_latency", ack_cyc[base] - start, 32'd2);
        check_val("read_strobes", rd_cnt - rc, 32'(good && !we));
        check_val("write_strobes", wr_cnt - wc, 32'(good && we));
        if (good) check_val("strobe_cycle", (we ? wr_cyc : rd_cyc) - start, 32'd1);
    endtask

    initial begin
        int base, start;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        apply_reset();
        check_val("rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
        check_val("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_a", 32'(a), 32'd0);
        check_val("rst_wd", wd, 32'd0);
        check_val("rst_funct3", 32'(Funct3), 32'd0);

        // Single-requester traffic: store/load, errors, sub-word loads and stores.
        access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
        access(1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        access(1'b1, 1'b1, 9'h020, 32'h12345678, 3'b010);
        access(1'b0, 1'b0, 9'h012, 32'h0, 3'b010);
        access(1'b0, 1'b0, 9'h013, 32'h0, 3'b001);
        access(1'b1, 1'b1, 9'h014, 32'hCAFEF00D, 3'b100);
        access(1'b0, 1'b0, 9'h010, 32'h0, 3'b000);
        access(1'b1, 1'b0, 9'h011, 32'h0, 3'b100);
        access(1'b1, 1'b0, 9'h012, 32'h0, 3'b101);
        access(1'b0, 1'b0, 9'h011, 32'h0, 3'b011);
        access(1'b0, 1'b1, 9'h030, 32'hA5A51234, 3'b001);
        access(1'b1, 1'b1, 9'h031, 32'h00000080, 3'b000);
        access(1'b0, 1'b0, 9'h030, 32'h0, 3'b001);
        access(1'b1, 1'b0, 9'h030, 32'h0, 3'b101);

        // Both requesters held high from reset: grants alternate 0,1,0,1.
        apply_reset();
        push_exp(1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        push_exp(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        push_exp(1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        push_exp(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        base = ack_cnt; start = cyc;
        set_req(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'b010);
        set_req(1'b1, 1'b1, 1'b0, 9'h020, '0, 3'b010);
        wait_acks(base + 4, 40);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        if (ack_cyc.size() >= base + 4) begin
            check_val("tie_first_ack", ack_cyc[base] - start, 32'd2);
            for (int k = 1; k < 4; k++)
                check_val("tie_ack_spacing", ack_cyc[base+k] - ack_cyc[base+k-1], 32'd3);
        end

        // Reset while the access is in ISSUE: it is dropped, then port 0 wins the tie.
        @(negedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'b010);
        @(negedge clk); #1;
        check_val("mid_rst_issue", 32'(MemRead), 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        check_val("mid_rst_ack", 32'({ack0, ack1}), 32'd0);
        check_val("mid_rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
        check_val("mid_rst_a", 32'(a), 32'd0);
        push_exp(1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        push_exp(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        base = ack_cnt; start = cyc;
        set_req(1'b1, 1'b1, 1'b0, 9'h020, '0, 3'b010);
        wait_acks(base + 2, 20);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        if (ack_cyc.size() > base) check_val("post_rst_latency", ack_cyc[base] - start, 32'd2);

        // Requester 1 keeps req high after its ack: re-granted as a new access.
        @(negedge clk); #1;
        push_exp(1'b1, 1'b0, 9'h020, 32'h0, 3'b000);
        push_exp(1'b1, 1'b0, 9'h020, 32'h0, 3'b000);
        base = ack_cnt; start = cyc;
        set_req(1'b1, 1'b1, 1'b0, 9'h020, '0, 3'b000);
        wait_acks(base + 2, 20);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        if (ack_cyc.size() >= base + 2) begin
            check_val("held_ack1", ack_cyc[base] - start, 32'd2);
            check_val("held_ack2", ack_cyc[base+1] - start, 32'd5);
        end

        repeat (5) @(negedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the datamemory block.
- Requester 0 is the core load/store path; requester 1 is the program loader/debug port.
- Each access is checked for alignment and funct3 legality, issued to memory for exactly one cycle, and completed with a one-cycle ack pulse plus registered load data.

Parameters:
- DM_ADDRESS, 9: address width to memory.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  DM_ADDRESS  byte address.
- wdata0 / wdata1  in  DATA_W  store data.
- funct3_0 / funct3_1  in  3  RISC-V load/store funct3.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; access rejected.
- rdata  out  DATA_W  load result; valid with either ack.
- MemRead  out  1  to datamemory.
- MemWrite  out  1  to datamemory.
- a  out  DM_ADDRESS  to datamemory.
- wd  out  DATA_W  to datamemory.
- Funct3  out  3  to datamemory.
- rd  in  DATA_W  read data from datamemory.

Behaviour:
- Reset (synchronous, takes priority over any state):
  - state = IDLE; last = 1, so requester 0 wins the first tie.
  - ack0, ack1, err0 and err1 are 0.
  - rdata, a, wd and Funct3 are 0; MemRead and MemWrite are 0.
  - Any in-flight access is dropped, with no ack.
- Handshake:
  - A requester holds req and all its fields stable until its ack.
  - It deasserts req in the cycle after ack, unless it is issuing a new request.
  - If req is still high when the arbiter returns to IDLE, that counts as a new request.
- FSM states are IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester other than `last` wins.
  - On a win: latch the winner's we/addr/wdata/funct3 and the winner id into a, wd, Funct3 and internal registers; compute `bad`; go to ISSUE.
- bad = 1 when any of the following holds:
  - Store with funct3 not in {000, 001, 010}.
  - Load with funct3 not in {000, 001, 010, 100, 101}.
  - funct3 = 010 and a[1:0] != 0.
  - funct3 in {001, 101} and a[0] != 0.
- ISSUE (exactly one cycle):
  - If bad = 0: MemRead = !we, MemWrite = we.
  - If bad = 1: both are 0.
  - At the end of the cycle, rdata <= rd for a good load; otherwise rdata <= 0.
  - Go to RESP.
- RESP (exactly one cycle):
  - ack of the winner = 1; err of the winner = bad.
  - last <= winner id.
  - Go to IDLE.
- Outside ISSUE, MemRead and MemWrite are 0.
- a, wd and Funct3 hold their latched values until the next grant.
- Latency: request seen in IDLE at cycle N -> memory strobe at N+1 -> ack at N+2. Peak throughput is one access per 3 cycles.
- ack0 and ack1 are never high together. The non-winning requester is ignored until the next IDLE.
- rdata holds its value until the next ISSUE.

Test Plan:
- Load after store (req0 only):
  - SW to a=0x010 with wdata0=0xDEADBEEF -> MemWrite high exactly 1 cycle (cycle 1), ack0 at cycle 2, err0=0.
  - Then LW from a=0x010 -> MemRead 1 cycle, ack0 with rdata=0xDEADBEEF.
- Simultaneous requests from reset:
  - req0 and req1 both held high -> grants in order 0, 1, 0, 1.
  - Acks 3 cycles apart; ack0 and ack1 never together.
- Misaligned and illegal accesses:
  - LW at a=0x012 -> no MemRead/MemWrite; ack with err=1 and rdata=0.
  - LH at a=0x013 -> same as above.
  - Store with funct3=100 -> same as above.
- Byte load:
  - LB at a=0x010 after the SW above -> rdata equals the memory's sign-extended byte (0xFFFFFFEF); err=0.
- Reset mid-access:
  - Assert reset during ISSUE -> next cycle state is IDLE, no ack, MemRead/MemWrite 0.
  - Afterwards, with both requests pending, requester 0 is granted first.
- Requester keeps req high after ack:
  - req1 held high after its ack -> re-granted as a new access; first ack at cycle 2, second at cycle 5.
